// File: rtl/frame_aligner_pkg.sv
// frame_aligner shared definitions: FAS bytes, hunt/lock states.
// Used by frame_aligner and its fas_detect hold/compare stage.
package frame_aligner_pkg;

  localparam logic [7:0] FAS0 = 8'hF6;
  localparam logic [7:0] FAS1 = 8'h28;
  localparam int DEF_FRAME_BYTES = 4096;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  function automatic logic [12:0] pos_next(
    input logic [12:0] p,
    input logic [12:0] last
  );
    return (p == last) ? 13'd0 : p + 13'd1;
  endfunction

endpackage

// File: rtl/frame_aligner_fas_detect.sv
// fas_detect: hold register for the previous accepted byte plus the
// two-byte FAS compare against the byte being accepted now.
module fas_detect
  import frame_aligner_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       match,
  output logic [7:0] prev
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (valid) begin
      prev <= data;
    end
  end

  assign match = valid && (prev == FAS0) && (data == FAS1);

endmodule

// File: rtl/frame_aligner.sv
// frame_aligner: FAS hunt/confirm/hold and one-byte-delayed output.
// FRAME_ALIGNER_STATS_EN adds saturating FAS error and resync counters.
module frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter int FRAME_BYTES  = DEF_FRAME_BYTES,
  parameter int SYNC_CONFIRM = 2,
  parameter int LOSS_CNT     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_valid,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_in_sync,
  output logic        o_sync_lost
`ifdef FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0] o_fas_err_cnt,
  output logic [7:0]  o_resync_cnt
`endif
);

  localparam logic [12:0] LAST = 13'(FRAME_BYTES - 1);
  localparam logic [7:0]  CONF = 8'(SYNC_CONFIRM);
  localparam logic [7:0]  LOSS = 8'(LOSS_CNT);

  state_t      state;
  logic [12:0] pos;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;
  logic [7:0]  hit_nxt;
  logic [7:0]  miss_nxt;
  logic [7:0]  prev;
  logic        match;
  logic        check;

  fas_detect u_fas (
    .clk   (i_clk),
    .rst_n (i_rst),
    .data  (i_rx_data),
    .valid (i_rx_data_valid),
    .match (match),
    .prev  (prev)
  );

  // pos is the slot of the byte being accepted; slot 1 completes FAS.
  assign check    = i_rx_data_valid && (pos == 13'd1);
  assign hit_nxt  = hit_cnt + 8'd1;
  assign miss_nxt = miss_cnt + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state              <= HUNT;
      pos                <= '0;
      hit_cnt            <= '0;
      miss_cnt           <= '0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_in_sync          <= 1'b0;
      o_sync_lost        <= 1'b0;
    end else begin
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_sync_lost        <= 1'b0;
      if (i_rx_data_valid) begin
        o_frame_data <= prev;
        pos          <= pos_next(pos, LAST);
        unique case (state)
          HUNT: begin
            if (match) begin
              pos      <= 13'd2;
              hit_cnt  <= 8'd1;
              miss_cnt <= '0;
              if (CONF <= 8'd1) begin
                state              <= SYNC;
                o_in_sync          <= 1'b1;
                o_frame_data_valid <= 1'b1;
                o_frame_data_fas   <= 1'b1;
              end else begin
                state <= PRESYNC;
              end
            end
          end
          PRESYNC: begin
            if (check) begin
              if (match && hit_nxt >= CONF) begin
                state              <= SYNC;
                miss_cnt           <= '0;
                o_in_sync          <= 1'b1;
                o_frame_data_valid <= 1'b1;
                o_frame_data_fas   <= 1'b1;
              end else if (match) begin
                hit_cnt <= hit_nxt;
              end else begin
                state   <= HUNT;
                hit_cnt <= '0;
              end
            end
          end
          SYNC: begin
            o_frame_data_valid <= 1'b1;
            o_frame_data_fas   <= check;
            if (check && match) begin
              miss_cnt <= '0;
            end else if (check && miss_nxt >= LOSS) begin
              state              <= HUNT;
              hit_cnt            <= '0;
              miss_cnt           <= '0;
              o_in_sync          <= 1'b0;
              o_sync_lost        <= 1'b1;
              o_frame_data_valid <= 1'b0;
              o_frame_data_fas   <= 1'b0;
            end else if (check) begin
              miss_cnt <= miss_nxt;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef FRAME_ALIGNER_STATS_EN
  logic sync_miss;
  logic hunt_entry;

  assign sync_miss  = (state == SYNC) && check && !match;
  assign hunt_entry = (state == HUNT) && match && (CONF > 8'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fas_err_cnt <= '0;
      o_resync_cnt  <= '0;
    end else begin
      if (sync_miss && o_fas_err_cnt != '1) begin
        o_fas_err_cnt <= o_fas_err_cnt + 16'd1;
      end
      if (hunt_entry && o_resync_cnt != '1) begin
        o_resync_cnt <= o_resync_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/frame_aligner.md
Name: frame_aligner

Overview:
Receive-side frame aligner between the serial receiver and the demapper. It searches the raw byte stream for the two-byte frame alignment signal (FAS), then confirms and holds frame lock. Once locked it forwards bytes with valid and a FAS flag on byte 0 of each frame. It drives the demapper's i_frame_data/i_frame_data_valid/i_frame_data_fas.

Parameters:
FRAME_BYTES, 4096, bytes per frame including FAS (4 rows x 1024 cols); must be >= 4 and <= 8192
SYNC_CONFIRM, 2, consecutive FAS hits (including the first detection) required to declare lock
LOSS_CNT, 3, consecutive FAS misses in SYNC that drop lock

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-low (0 = reset)
i_rx_data  in  8  byte from serial receiver
i_rx_data_valid  in  1  byte strobe; may gap arbitrarily
o_frame_data  out  8  aligned byte to demapper
o_frame_data_valid  out  1  output byte strobe; only asserted in SYNC
o_frame_data_fas  out  1  marks frame byte 0 (FAS0); qualified by valid
o_in_sync  out  1  level; 1 while state == SYNC
o_sync_lost  out  1  one-cycle pulse on SYNC -> HUNT

Behaviour:
- FAS = FAS0 8'hF6 at frame position 0, then FAS1 8'h28 at position 1.
- Reset (i_rst low, async): state HUNT; pos, hit, miss and hold register cleared; all outputs 0.
- pos: 13-bit position counter. Advances only on i_rx_data_valid. Wraps FRAME_BYTES-1 -> 0. In HUNT, a match loads pos = 2 for the next byte.
- Hold register: holds the previously accepted byte (prev), loaded on every valid.
- Match = i_rx_data_valid && prev == FAS0 && i_rx_data == FAS1.
- Check point: accepted byte at pos == 1 while in PRESYNC or SYNC. hit = Match; miss = !Match.
- States:
  - HUNT: Match -> PRESYNC, hit_cnt = 1 (SYNC_CONFIRM = 1 goes straight to SYNC).
  - PRESYNC: at check point, hit -> hit_cnt+1; reaching SYNC_CONFIRM -> SYNC. Miss -> HUNT, hit_cnt = 0. The same pair is not re-evaluated as a HUNT match.
  - SYNC: at check point, hit clears miss_cnt; miss increments it. miss_cnt reaching LOSS_CNT -> HUNT and o_sync_lost = 1 for one cycle. Below LOSS_CNT, position flywheels.
- Output latency: byte B_n is presented one clock after B_n+1 is accepted (hold register drains on the next valid). Output pulses once per input valid.
- Output gating: valid = 1 when the drained byte belongs to SYNC. This includes FAS0 of the confirming frame, i.e. the PRESYNC -> SYNC transition cycle.
  - FAS0 of the frame whose check causes loss is not output (valid 0).
  - fas = 1 iff the drained byte's pos == 0, even if FAS mismatched (flywheel).
- No valid on a cycle leaves o_frame_data_valid = 0; data holds its last value.
- Valid gaps never change pos or state.
- Reset mid-frame: immediate return to HUNT; no partial frame is flagged afterward.

Optional Feature:
FRAME_ALIGNER_STATS_EN
- Defined: adds outputs o_fas_err_cnt (16 b) and o_resync_cnt (8 b).
  - o_fas_err_cnt counts every SYNC miss.
  - o_resync_cnt counts every HUNT -> PRESYNC entry.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header frame_defs.vh: FAS0/FAS1 constants, state encodings (HUNT = 2'd0, PRESYNC = 2'd1, SYNC = 2'd2), default FRAME_BYTES. The demapper fpc and mapper use the same header.
- One sub-module, fas_detect: hold register plus Match compare, 1 bit out.
- State machine, counters and output stage stay in frame_aligner.

Test Plan:
- Clean lock (FRAME_BYTES = 16): 5 back-to-back frames, FAS at 0/1 -> o_in_sync rises on the FAS0 output of frame 2. First valid output is F6 with fas = 1. Every 16th valid byte after it carries fas = 1.
- Offset/false FAS: 7 junk bytes, then a fake F6 28 inside frame 1 payload, then true framing -> PRESYNC entered on the fake pair, miss at next check, HUNT, lock on true FAS after 2 hits.
- Loss/flywheel: after lock, corrupt FAS1 in 2 frames -> stays in SYNC with fas still pulsing. Corrupt 3 consecutive -> o_sync_lost one-cycle pulse, o_in_sync = 0, that frame's FAS0 not output.
- Gapped input: insert random 0-3 idle cycles between bytes -> identical output byte sequence and fas positions. Valid never asserted on idle-following cycles without new input.
- Async reset mid-frame in SYNC: all outputs 0 in the same cycle without a clock edge. After release, re-lock takes 2 frames.
- Stats (macro defined): 5 misses spread so lock holds -> o_fas_err_cnt = 5. Force 300 resyncs -> o_resync_cnt = 255.
